// File: rtl/ftdi_fifo_bridge.sv
// ftdi_fifo_bridge: buffers bytes between a push/pop stream interface and an FTDI async FIFO bus
// using timed rd/wr strobes, with a fair RX/TX token arbiter.
module ftdi_fifo_bridge #(
  parameter int DEPTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int T_RD_ACTIVE = 4,
  parameter int T_RD_SAMPLE = 3,
  parameter int T_DATA_TO_WR = 2,
  parameter int T_WR_ACTIVE = 4,
  parameter int T_RECOVER = SYNC_STAGES + 1,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          in_clk,
  input  logic          in_rst_n,
  input  logic          in_ftdi_rxf,
  input  logic          in_ftdi_txe,
  inout  wire  [7:0]    io_ftdi_data,
  output logic          out_ftdi_rd,
  output logic          out_ftdi_wr,
  input  logic          in_rx_ena,
  input  logic [7:0]    in_tx_data,
  input  logic          in_tx_valid,
  output logic          out_tx_ready,
  output logic [7:0]    out_rx_data,
  output logic          out_rx_valid,
  input  logic          in_rx_ready,
  output logic [LW-1:0] out_tx_level,
  output logic [LW-1:0] out_rx_level
);
  typedef enum logic [2:0] {IDLE, RD_STROBE, WR_SETUP, WR_STROBE, RECOVER} state_t;
  localparam logic [15:0] RD_SAMPLE_CNT = 16'(T_RD_ACTIVE - T_RD_SAMPLE);
  state_t state;
  logic [15:0] cnt;
  logic token_tx, drv;
  logic [7:0] dout;
  logic [SYNC_STAGES-1:0] rxf_q, txe_q;
  logic rxf_s, txe_s, rd_ok, wr_ok, rx_push, rx_pop, tx_push, tx_pop;
  logic [7:0] tx_mem [DEPTH];
  logic [7:0] rx_mem [DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  assign io_ftdi_data = drv ? dout : 8'hzz;
  assign rxf_s = rxf_q[SYNC_STAGES-1];
  assign txe_s = txe_q[SYNC_STAGES-1];
  assign out_tx_ready = out_tx_level != LW'(DEPTH);
  assign out_rx_valid = out_rx_level != '0;
  assign out_rx_data = out_rx_valid ? rx_mem[rx_rp] : 8'h00;
  assign tx_push = in_tx_valid && out_tx_ready;
  assign rx_pop = out_rx_valid && in_rx_ready;
  assign rd_ok = in_rx_ena && rxf_s && out_rx_level < LW'(DEPTH);
  assign wr_ok = txe_s && out_tx_level != '0;
  // counter runs down through the strobe, so the sample cycle maps to a fixed count
  assign rx_push = state == RD_STROBE && cnt == RD_SAMPLE_CNT;
  assign tx_pop = state == WR_STROBE && cnt == '0;
  always_ff @(posedge in_clk or negedge in_rst_n)
    if (!in_rst_n) begin
      rxf_q <= '0;
      txe_q <= '0;
    end else begin
      rxf_q <= {rxf_q[SYNC_STAGES-2:0], in_ftdi_rxf};
      txe_q <= {txe_q[SYNC_STAGES-2:0], in_ftdi_txe};
    end
  always_ff @(posedge in_clk or negedge in_rst_n)
    if (!in_rst_n) begin
      state <= IDLE;
      cnt <= '0;
      token_tx <= 1'b0;
      out_ftdi_rd <= 1'b0;
      out_ftdi_wr <= 1'b0;
      drv <= 1'b0;
      dout <= '0;
    end else begin
      case (state)
        IDLE:
          if (rd_ok && (!token_tx || !wr_ok)) begin
            state <= RD_STROBE;
            out_ftdi_rd <= 1'b1;
            cnt <= 16'(T_RD_ACTIVE - 1);
          end else if (wr_ok) begin
            state <= WR_SETUP;
            drv <= 1'b1;
            dout <= tx_mem[tx_rp];
            cnt <= 16'(T_DATA_TO_WR - 1);
          end
        RD_STROBE:
          if (cnt == '0) begin
            state <= RECOVER;
            out_ftdi_rd <= 1'b0;
            token_tx <= 1'b1;
            cnt <= 16'(T_RECOVER - 1);
          end else cnt <= cnt - 16'd1;
        WR_SETUP:
          if (cnt == '0) begin
            state <= WR_STROBE;
            out_ftdi_wr <= 1'b1;
            cnt <= 16'(T_WR_ACTIVE - 1);
          end else cnt <= cnt - 16'd1;
        WR_STROBE:
          if (cnt == '0) begin
            state <= RECOVER;
            out_ftdi_wr <= 1'b0;
            drv <= 1'b0;
            token_tx <= 1'b0;
            cnt <= 16'(T_RECOVER - 1);
          end else cnt <= cnt - 16'd1;
        RECOVER:
          if (cnt == '0) state <= IDLE;
          else cnt <= cnt - 16'd1;
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge in_clk) begin
    if (tx_push) tx_mem[tx_wp] <= in_tx_data;
    if (rx_push) rx_mem[rx_wp] <= io_ftdi_data;
  end
  always_ff @(posedge in_clk or negedge in_rst_n)
    if (!in_rst_n) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
      out_tx_level <= '0;
      out_rx_level <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop) tx_rp <= tx_rp + AW'(1);
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop) rx_rp <= rx_rp + AW'(1);
      out_tx_level <= out_tx_level + LW'(tx_push) - LW'(tx_pop);
      out_rx_level <= out_rx_level + LW'(rx_push) - LW'(rx_pop);
    end
endmodule

// File: tb/tb_ftdi_fifo_bridge.sv
// tb_ftdi_fifo_bridge: randomized checks of ftdi_fifo_bridge against a queue-based FTDI and FIFO model
module tb_ftdi_fifo_bridge;
  localparam int T_RD = 4, T_SMP = 3, T_SU = 2, T_WR = 4, T_REC = 3, DEP = 8;
  localparam int B_RD = 6;
  logic clk = 0, rst_n = 1, b_rst_n = 1;
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  logic rxf = 0, txe = 0, rx_ena = 0, tx_valid = 0, rx_ready = 0;
  logic [7:0] tx_data = 0, fd = 0, rx_data;
  wire [7:0] bus;
  logic rd, wr, tx_ready, rx_valid;
  logic [3:0] tx_level, rx_level;
  assign bus = rd ? fd : 8'hzz;
  ftdi_fifo_bridge dut (
    .in_clk(clk), .in_rst_n(rst_n), .in_ftdi_rxf(rxf), .in_ftdi_txe(txe), .io_ftdi_data(bus),
    .out_ftdi_rd(rd), .out_ftdi_wr(wr), .in_rx_ena(rx_ena), .in_tx_data(tx_data),
    .in_tx_valid(tx_valid), .out_tx_ready(tx_ready), .out_rx_data(rx_data), .out_rx_valid(rx_valid),
    .in_rx_ready(rx_ready), .out_tx_level(tx_level), .out_rx_level(rx_level)
  );
  logic b_rx_ready = 0;
  logic [7:0] b_fd = 0, b_rx_data;
  wire [7:0] b_bus;
  logic b_rd, b_wr, b_tx_ready, b_rx_valid;
  logic [2:0] b_tx_level, b_rx_level;
  assign b_bus = b_rd ? b_fd : 8'hzz;
  ftdi_fifo_bridge #(.DEPTH(4), .T_RD_ACTIVE(B_RD), .T_RD_SAMPLE(B_RD)) dut_b (
    .in_clk(clk), .in_rst_n(b_rst_n), .in_ftdi_rxf(1'b1), .in_ftdi_txe(1'b0), .io_ftdi_data(b_bus),
    .out_ftdi_rd(b_rd), .out_ftdi_wr(b_wr), .in_rx_ena(1'b1), .in_tx_data(8'h00),
    .in_tx_valid(1'b0), .out_tx_ready(b_tx_ready), .out_rx_data(b_rx_data), .out_rx_valid(b_rx_valid),
    .in_rx_ready(b_rx_ready), .out_tx_level(b_tx_level), .out_rx_level(b_rx_level)
  );
  logic [7:0] txq[$], rxq[$], hist[$], b_rxq[$];
  logic [7:0] src = 8'hA5, b_src = 8'h3C, head;
  int rd_run = 0, wr_run = 0, gap = 100, last_type = -1, alt_n = 0, rd_starts = 0;
  int b_run = 0, b_got = 0;
  bit alt_on = 0, b_done = 0;
  task automatic note_access(input int t);
    if (alt_on && alt_n > 0 && alt_n < 6) check("alternate", 32'(t), 32'(last_type == 0 ? 1 : 0));
    if (alt_on) alt_n++;
    last_type = t;
  endtask
  // FTDI side model: answers reads with a byte that is only correct in the sample cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      txq.delete();
      rxq.delete();
      rd_run = 0;
      wr_run = 0;
      gap = 100;
    end else begin
      check("rd_wr_excl", 32'(rd & wr), 0);
      if (!wr && wr_run > 0) begin
        check("wr_len", wr_run, T_WR);
        if (txq.size() > 0) void'(txq.pop_front());
        wr_run = 0;
        gap = 0;
      end
      if (!rd && rd_run > 0) begin
        check("rd_len", rd_run, T_RD);
        rd_run = 0;
        gap = 0;
      end
      head = txq.size() > 0 ? txq[0] : 8'h00;
      check("tx_level", 32'(tx_level), txq.size());
      check("rx_level", 32'(rx_level), rxq.size());
      check("tx_ready", 32'(tx_ready), 32'(txq.size() != DEP));
      check("rx_valid", 32'(rx_valid), 32'(rxq.size() != 0));
      if (wr) begin
        if (wr_run == 0) begin
          check("wr_gap", 32'(gap >= T_REC + T_SU), 1);
          check("wr_has_data", 32'(txq.size() > 0), 1);
          if (hist.size() >= T_SU)
            for (int i = 0; i < T_SU; i++) check("wr_setup_bus", 32'(hist[hist.size()-1-i]), 32'(head));
          note_access(1);
        end
        wr_run++;
        check("wr_bus", 32'(bus), 32'(head));
      end
      if (rd) begin
        if (rd_run == 0) begin
          check("rd_gap", 32'(gap >= T_REC), 1);
          rd_starts++;
          note_access(0);
        end
        rd_run++;
        if (rd_run == T_SMP) begin
          fd = src;
          rxq.push_back(src);
          src = 8'($urandom);
        end else fd = ~src;
      end
      if (rx_valid && rx_ready) begin
        check("rx_data", 32'(rx_data), 32'(rxq.size() > 0 ? rxq[0] : 8'h00));
        if (rxq.size() > 0) void'(rxq.pop_front());
      end
      if (tx_valid && tx_ready) txq.push_back(tx_data);
      if (!rd && !wr) gap++;
    end
    hist.push_back(bus);
    if (hist.size() > 8) void'(hist.pop_front());
  end
  always @(negedge clk) begin
    if (b_rst_n) begin
      check("b_rx_level", 32'(b_rx_level), b_rxq.size());
      check("b_wr_idle", 32'(b_wr), 0);
      if (!b_rd && b_run > 0) begin
        check("b_rd_len", b_run, B_RD);
        b_run = 0;
      end
      if (b_rd) begin
        b_run++;
        if (b_run == B_RD) begin
          b_fd = b_src;
          b_rxq.push_back(b_src);
          b_src = 8'($urandom);
        end else b_fd = ~b_src;
      end
      if (b_rx_valid && b_rx_ready) begin
        check("b_rx_data", 32'(b_rx_data), 32'(b_rxq.size() > 0 ? b_rxq[0] : 8'h00));
        if (b_rxq.size() > 0) void'(b_rxq.pop_front());
        b_got++;
      end
    end
  end
  initial begin
    #1 b_rst_n = 0;
    step(3);
    b_rst_n = 1;
    for (int i = 0; i < 1500 && b_got < 12; i++) begin
      b_rx_ready = $urandom_range(2) == 0;
      step(1);
    end
    check("b_wrap_done", 32'(b_got >= 12), 1);
    b_done = 1;
  end
  initial begin
    int n, n1, n2, snap;
    #1 rst_n = 0;
    step(3);
    check("rst_rd", 32'(rd), 0);
    check("rst_wr", 32'(wr), 0);
    check("rst_tx_ready", 32'(tx_ready), 1);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_levels", 32'({tx_level, rx_level}), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    rxf = 1;
    rx_ena = 1;
    rst_n = 1;
    n = 0;
    while (!rd && n < 50) begin step(1); n++; end
    while (rd && n < 50) begin step(1); n++; end
    check("first_rd_timeout", 32'(n < 50), 1);
    check("first_rx_level", 32'(rx_level), 1);
    check("first_rx_valid", 32'(rx_valid), 1);
    check("first_rx_data", 32'(rx_data), 32'h a5);
    rxf = 0;
    step(20);
    tx_valid = 1;
    tx_data = 8'h11;
    step(1);
    tx_data = 8'h22;
    step(1);
    tx_valid = 0;
    check("w_level2", 32'(tx_level), 2);
    txe = 1;
    n = 0;
    while (!wr && n < 100) begin step(1); n++; end
    n1 = 0;
    while (wr && n1 < 20) begin step(1); n1++; end
    check("w1_len", n1, T_WR);
    check("w1_level", 32'(tx_level), 1);
    n2 = 0;
    while (!wr && n2 < 20) begin step(1); n2++; end
    check("w_gap_min", 32'(n2 >= T_REC + T_SU), 1);
    check("w_gap_max", 32'(n2 <= T_REC + T_SU + 1), 1);
    n1 = 0;
    while (wr && n1 < 20) begin step(1); n1++; end
    check("w2_len", n1, T_WR);
    check("w2_level", 32'(tx_level), 0);
    txe = 0;
    rx_ready = 1;
    step(20);
    for (int i = 0; i < 3; i++) begin
      tx_valid = 1;
      tx_data = 8'($urandom);
      step(1);
    end
    tx_valid = 0;
    alt_n = 0;
    alt_on = 1;
    rxf = 1;
    txe = 1;
    n = 0;
    while (alt_n < 6 && n < 300) begin step(1); n++; end
    check("alt_done", 32'(alt_n >= 6), 1);
    alt_on = 0;
    rxf = 0;
    txe = 0;
    step(25);
    for (int i = 0; i < 9; i++) begin
      tx_valid = 1;
      tx_data = 8'($urandom);
      step(1);
    end
    tx_valid = 0;
    check("tx_full_ready", 32'(tx_ready), 0);
    check("tx_full_level", 32'(tx_level), DEP);
    rx_ready = 0;
    rxf = 1;
    n = 0;
    while (rx_level != 4'(DEP) && n < 300) begin step(1); n++; end
    check("rx_fill", 32'(rx_level), DEP);
    step(10);
    snap = rd_starts;
    step(40);
    check("rx_full_no_rd", rd_starts - snap, 0);
    txe = 1;
    n = 0;
    while (!wr && n < 100) begin step(1); n++; end
    step(1);
    check("pre_rst_wr", 32'(wr), 1);
    rst_n = 0;
    #1;
    check("rst_async_wr", 32'(wr), 0);
    check("rst_async_rd", 32'(rd), 0);
    step(2);
    rst_n = 1;
    #1;
    check("post_rst_levels", 32'({tx_level, rx_level}), 0);
    check("post_rst_quiet0", 32'(rd | wr), 0);
    step(1);
    check("post_rst_quiet1", 32'(rd | wr), 0);
    step(1);
    check("post_rst_quiet2", 32'(rd | wr), 0);
    for (int i = 0; i < 3000; i++) begin
      tx_valid = $urandom_range(1);
      tx_data = 8'($urandom);
      rxf = $urandom_range(3) != 0;
      txe = $urandom_range(3) != 0;
      rx_ena = $urandom_range(4) != 0;
      rx_ready = $urandom_range(1);
      step(1);
    end
    tx_valid = 0;
    rxf = 0;
    txe = 1;
    rx_ready = 1;
    step(300);
    check("drain_tx", 32'(tx_level), 0);
    check("drain_rx", 32'(rx_level), 0);
    n = 0;
    while (!b_done && n < 2000) begin step(1); n++; end
    check("b_finished", 32'(b_done), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/ftdi_fifo_bridge.md
FTDI_FIFO_BRIDGE -- requirements
Module: ftdi_fifo_bridge

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entries per internal FIFO; power of 2, 2..256.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser flops on in_ftdi_rxf/in_ftdi_txe, range 2..3.
REQ-003 SHALL have parameter T_RD_ACTIVE, default 4, cycles out_ftdi_rd held high.
REQ-004 SHALL have parameter T_RD_SAMPLE, default 3, strobe cycle (1-based) on whose closing edge the bus is sampled; 1..T_RD_ACTIVE.
REQ-005 SHALL have parameter T_DATA_TO_WR, default 2, cycles the bus is driven before out_ftdi_wr rises.
REQ-006 SHALL have parameter T_WR_ACTIVE, default 4, cycles out_ftdi_wr held high.
REQ-007 SHALL have parameter T_RECOVER, default SYNC_STAGES+1, idle cycles after any strobe.
REQ-008 in_clk  input  1  sole clock, rising edge.
REQ-009 in_rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-010 in_ftdi_rxf  input  1  high = FTDI holds a byte for us to read.
REQ-011 in_ftdi_txe  input  1  high = FTDI accepts a write.
REQ-012 io_ftdi_data  inout  8  FTDI data bus.
REQ-013 out_ftdi_rd / out_ftdi_wr  output  1 each  read / write strobes, active high.
REQ-014 in_rx_ena  input  1  permits new FTDI reads.
REQ-015 in_tx_data  input  8, in_tx_valid  input  1, out_tx_ready  output  1  TX push port.
REQ-016 out_rx_data  output  8, out_rx_valid  output  1, in_rx_ready  input  1  RX pop port.
REQ-017 out_tx_level / out_rx_level  output  $clog2(DEPTH)+1 each  FIFO occupancy.

Function
REQ-018 TX FIFO push on in_tx_valid && out_tx_ready; out_tx_ready = (out_tx_level != DEPTH); a pop in the same cycle does not make ready high when full.
REQ-019 RX FIFO show-ahead: out_rx_valid = (out_rx_level != 0), out_rx_data = head; pop on out_rx_valid && in_rx_ready; simultaneous push and pop leaves level unchanged.
REQ-020 FIFO pointers wrap modulo DEPTH; levels never exceed DEPTH nor underflow.
REQ-021 rxf_s/txe_s = in_ftdi_rxf/in_ftdi_txe after SYNC_STAGES flops; FSM uses only synchronised values.
REQ-022 FSM states IDLE, RD_STROBE, WR_SETUP, WR_STROBE, RECOVER; single down-counter for all durations.
REQ-023 rd_ok = in_rx_ena && rxf_s && out_rx_level < DEPTH; wr_ok = txe_s && out_tx_level != 0.
REQ-024 IDLE: token=RX -> rd_ok ? RD_STROBE : wr_ok ? WR_SETUP : IDLE; token=TX -> priorities swapped.
REQ-025 RD_STROBE: out_ftdi_rd=1 for exactly T_RD_ACTIVE cycles; bus pushed into RX FIFO at closing edge of strobe cycle T_RD_SAMPLE; token<=TX; then RECOVER.
REQ-026 WR_SETUP: bus driven with TX head, out_ftdi_wr=0, T_DATA_TO_WR cycles; then WR_STROBE.
REQ-027 WR_STROBE: bus driven, out_ftdi_wr=1 for T_WR_ACTIVE cycles; TX pop at last cycle; token<=RX; then RECOVER.
REQ-028 RECOVER: all strobes low, bus released, T_RECOVER cycles, then IDLE; no new access in RECOVER.
REQ-029 Bus driven only in WR_SETUP/WR_STROBE, else high-Z; out_ftdi_rd, out_ftdi_wr, drive enable SHALL be flop outputs (glitch-free).
REQ-030 rd and wr SHALL never be high in the same cycle; drive enable never high while rd high.
REQ-031 in_rx_ena low or rxf_s falling mid-RD_STROBE SHALL NOT shorten the strobe.
REQ-032 txe_s falling during WR_SETUP/WR_STROBE SHALL NOT abort the write.

Reset
REQ-033 in_rst_n low: state IDLE, counter 0, token RX, both FIFOs empty, out_ftdi_rd=0, out_ftdi_wr=0, bus high-Z, out_tx_ready=1, out_rx_valid=0, levels 0, out_rx_data=0.
REQ-034 Reset mid-strobe: strobes fall and bus releases asynchronously, without waiting for a clock; first access starts no earlier than SYNC_STAGES+1 cycles after deassertion.

Verification
REQ-035 Defaults, rxf=1, in_rx_ena=1, bus=0xA5 -> rd high exactly 4 cycles, out_rx_valid next cycle, out_rx_data=0xA5, out_rx_level=1.
REQ-036 Push 0x11,0x22, txe=1 -> bus 0x11 driven 2 cycles before wr, wr high 4 cycles, then RECOVER 3 cycles, then 0x22 same pattern; out_tx_level 2->1->0.
REQ-037 rxf=1, txe=1, TX FIFO holds 3 bytes, in_rx_ready=1 -> accesses alternate read, write, read, write, ...
REQ-038 Push 8 bytes with txe=0 -> out_tx_ready=0, ninth push ignored, level stays 8; RX full with rxf=1 -> no rd strobe.
REQ-039 Assert in_rst_n=0 during wr cycle 2 -> wr and bus enable drop before next clock edge; after release levels 0, no strobe for 3 cycles.
REQ-040 DEPTH=4, T_RD_ACTIVE=6, T_RD_SAMPLE=6 -> rd 6 cycles, sample on last edge, pointers wrap after 4 pushes without data loss.
